alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-request ALU.
- Accepts one tagged operation per cycle on a valid/ready input handshake and computes result plus status flags through a configurable-depth pipeline.
- Returns results in order through an output FIFO with valid/ready backpressure.
- Sits between the transactor/DPI driver and downstream consumers; any number of requests may be outstanding, up to the FIFO depth.

---
 rtl/alu_pipe_pkg.sv | 24 ++
 rtl/alu_pipe_fifo.sv | 63 ++++++
 rtl/alu_pipe.sv | 159 +++++++++++++++
 tb/tb_alu_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcode and flag definitions for alu_pipe
// Purpose: opcode enumeration and flag bit positions used by the ALU pipeline
//          and its consumers. The result-entry struct is declared inside
//          alu_pipe because its field widths follow that module's parameters.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  // Bit positions within the 3-bit {V, C, Z} flag field.
  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 2;
  localparam int FLAGS_W = 3;

endpackage

// File: rtl/alu_pipe_fifo.sv
// rtl/alu_pipe_fifo.sv - synchronous first-word-fall-through FIFO
// Purpose: holds finished results in order; the head entry is visible on
//          head_o whenever count_o is non-zero.
// Ports:
//   clk, reset     clock, synchronous active-low reset (clears pointers/count)
//   push_i         write push_data_i this edge
//   push_data_i    entry to store
//   pop_i          consume the head entry this edge (ignored when empty)
//   head_o         entry at the head (undefined when count_o == 0)
//   count_o        number of stored entries, 0..DEPTH
module alu_pipe_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is left unreset; stale contents are never visible because
  // the count gates validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined tagged ALU with in-order output FIFO
// Purpose: accepts one tagged operation per cycle, computes result and
//          {V,C,Z} flags, carries them through STAGES registers and queues
//          them in an FWFT FIFO drained with valid/ready.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   in_valid/in_ready              request handshake
//   in_opa, in_opb, in_op, in_tag  operands, opcode, tag
//   out_valid/out_ready            result handshake
//   out_result, out_tag, out_flags result, tag, {V,C,Z}; zero when !out_valid
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 4,
  parameter int STAGES     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_opa,
  input  logic [WIDTH-1:0]   in_opb,
  input  logic [2:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic [FLAGS_W-1:0] out_flags
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0]   result;
    logic [TAG_W-1:0]   tag;
    logic [FLAGS_W-1:0] flags;
  } entry_t;

  op_e                op;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, sra_w;
  logic [WIDTH-1:0]   res;
  logic               c, v;
  entry_t             stage_d;
  entry_t             stage_q [STAGES];
  logic [STAGES-1:0]  vld_q;
  logic               accept, pop, live_q;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [OCC_W-1:0]   fifo_count;
  entry_t             head;

  assign op = op_e'(in_op);
  assign sh = in_opb[SHW-1:0];

  // One extra bit on each side captures carry/borrow or the last bit
  // shifted out; it reads 0 naturally when the shift amount is 0.
  assign add_w = {1'b0, in_opa} + {1'b0, in_opb};
  assign sub_w = {1'b0, in_opa} - {1'b0, in_opb};
  assign shl_w = {1'b0, in_opa} << sh;
  assign shr_w = {in_opa, 1'b0} >> sh;
  assign sra_w = $signed({in_opa, 1'b0}) >>> sh;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        res = add_w[WIDTH-1:0];
        c   = add_w[WIDTH];
        v   = (in_opa[WIDTH-1] == in_opb[WIDTH-1]) && (res[WIDTH-1] != in_opa[WIDTH-1]);
      end
      OP_SUB: begin
        res = sub_w[WIDTH-1:0];
        c   = sub_w[WIDTH];
        v   = (in_opa[WIDTH-1] != in_opb[WIDTH-1]) && (res[WIDTH-1] != in_opa[WIDTH-1]);
      end
      OP_AND: res = in_opa & in_opb;
      OP_OR:  res = in_opa | in_opb;
      OP_XOR: res = in_opa ^ in_opb;
      OP_SHL: begin
        res = shl_w[WIDTH-1:0];
        c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res = shr_w[WIDTH:1];
        c   = shr_w[0];
      end
      OP_SRA: begin
        res = sra_w[WIDTH:1];
        c   = sra_w[0];
      end
      default: res = '0;
    endcase
    stage_d.result         = res;
    stage_d.tag            = in_tag;
    stage_d.flags          = '0;
    stage_d.flags[FLAG_Z]  = (res == '0);
    stage_d.flags[FLAG_C]  = c;
    stage_d.flags[FLAG_V]  = v;
  end

  // live_q keeps in_ready low for every cycle the block is held in reset.
  assign in_ready  = live_q && (occ_q < OCC_W'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      live_q <= 1'b0;
      occ_q  <= '0;
      vld_q  <= '0;
    end else begin
      live_q   <= 1'b1;
      occ_q    <= occ_d;
      vld_q[0] <= accept;
      for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    stage_q[0] <= stage_d;
    for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
  end

  // occ bounds the in-flight count, so the FIFO always has room for the
  // last stage and the pipeline never needs to stall.
  alu_pipe_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (vld_q[STAGES-1]),
    .push_data_i (stage_q[STAGES-1]),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign out_result = out_valid ? head.result : '0;
  assign out_tag    = out_valid ? head.tag    : '0;
  assign out_flags  = out_valid ? head.flags  : '0;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_opa, in_opb;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [2:0]  out_flags;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opa     (in_opa),
    .in_opb     (in_opb),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [2:0]  flg;   // {V, C, Z}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic for carry/overflow, explicit bit picks for shifts.
  function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide, sr_u;
    longint      sa, sb, sr;
    logic [31:0] r;
    logic        c, v;
    int          sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin
        wide = {32'h0, a} + {32'h0, b};
        r = wide[31:0];
        c = wide[32];
        sr = sa + sb;
        sr_u = sr;
        v = !((&sr_u[63:31]) || !(|sr_u[63:31]));
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        sr = sa - sb;
        sr_u = sr;
        v = !((&sr_u[63:31]) || !(|sr_u[63:31]));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[32-sh];
      end
      3'd6: begin
        r = a >> sh;
        c = (sh == 0) ? 1'b0 : a[sh-1];
      end
      default: begin
        r = $signed(a) >>> sh;
        c = (sh == 0) ? 1'b0 : a[sh-1];
      end
    endcase
    return {v, c, (r == 32'h0), r};
  endfunction

  // Single request from idle with out_ready=1; checks the exact 2-stage latency.
  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_op = v.op; in_opa = v.a; in_opb = v.b; in_tag = v.tag; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, " ov@E"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, " ov@E+1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, " ov@E+2"}, 32'(out_valid), 32'd1);
    chk({nm, " result"}, out_result, v.res);
    chk({nm, " tag"}, 32'(out_tag), 32'(v.tag));
    chk({nm, " flags"}, 32'(out_flags), 32'(v.flg));
    @(negedge clk);
    chk({nm, " ov after pop"}, 32'(out_valid), 32'd0);
    chk({nm, " gated result"}, out_result, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [38:0] expq[$];
    logic [38:0] e;
    logic [34:0] m;
    int          nxt, got_n, first_c, last_c;
    logic        rdy, seen4;

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 4'd3,  32'h00000000, 3'b011};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h00000001, 4'd1,  32'h7FFFFFFF, 3'b100};
    vecs[2]  = '{3'd1, 32'h00000001, 32'h00000002, 4'd2,  32'hFFFFFFFF, 3'b010};
    vecs[3]  = '{3'd5, 32'h80000001, 32'h00000001, 4'd4,  32'h00000002, 3'b010};
    vecs[4]  = '{3'd7, 32'h80000000, 32'h0000001F, 4'd5,  32'hFFFFFFFF, 3'b000};
    vecs[5]  = '{3'd6, 32'h12345678, 32'h00000000, 4'd6,  32'h12345678, 3'b000};
    vecs[6]  = '{3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd7,  32'h00F000F0, 3'b000};
    vecs[7]  = '{3'd3, 32'h00000000, 32'h00000000, 4'd8,  32'h00000000, 3'b001};
    vecs[8]  = '{3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'd9,  32'h00000000, 3'b001};
    vecs[9]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 4'd10, 32'h80000000, 3'b100};
    vecs[10] = '{3'd6, 32'h00000001, 32'h00000001, 4'd11, 32'h00000000, 3'b011};
    vecs[11] = '{3'd5, 32'h0000000F, 32'h00000024, 4'd12, 32'h000000F0, 3'b000};
    vecs[12] = '{3'd7, 32'h40000000, 32'h0000001F, 4'd13, 32'h00000000, 3'b011};

    reset = 1'b0; in_valid = 1'b0; in_opa = '0; in_opb = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 32'(in_ready), 32'd1);
    chk("post-reset out_valid", 32'(out_valid), 32'd0);

    // Directed vectors
    for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: six offered, four accepted
    @(negedge clk);
    out_ready = 1'b0;
    nxt = 0;
    seen4 = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (nxt == 4 && !seen4) begin
        chk("bp in_ready after 4th accept", 32'(in_ready), 32'd0);
        seen4 = 1'b1;
      end
      rdy = in_ready;
      in_valid = (nxt < 6);
      in_op = OP_ADD; in_opa = 32'(nxt); in_opb = 32'd100; in_tag = 4'(nxt);
      @(posedge clk);
      if (rdy && nxt < 6) nxt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp accepted count", 32'(nxt), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("bp pop%0d valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp pop%0d tag", k), 32'(out_tag), 32'(k));
      chk($sformatf("bp pop%0d result", k), out_result, 32'(k + 100));
      if (k == 0) chk("bp in_ready before pop", 32'(in_ready), 32'd0);
      if (k == 1) chk("bp in_ready after first pop", 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    chk("bp drained", 32'(out_valid), 32'd0);

    // Streaming: 16 back-to-back random ops
    got_n = 0; first_c = -1; last_c = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          chk($sformatf("stream in_ready %0d", i), 32'(in_ready), 32'd1);
          in_opa = $urandom; in_opb = $urandom; in_op = 3'($urandom_range(0, 7));
          in_tag = 4'(i); in_valid = 1'b1;
          expq.push_back({in_tag, model(in_op, in_opa, in_opb)});
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 40; cyc++) begin
          @(negedge clk);
          if (out_valid) begin
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            got_n++;
            if (expq.size() == 0) begin
              chk("stream unexpected result", 32'(out_valid), 32'd0);
            end else begin
              e = expq.pop_front();
              chk($sformatf("stream%0d tag", got_n - 1), 32'(out_tag), 32'(e[38:35]));
              chk($sformatf("stream%0d result", got_n - 1), out_result, e[31:0]);
              chk($sformatf("stream%0d flags", got_n - 1), 32'(out_flags), 32'(e[34:32]));
            end
          end
        end
      end
    join
    chk("stream result count", 32'(got_n), 32'd16);
    chk("stream consecutive", 32'(last_c - first_c), 32'd15);

    // Reset with three requests in flight
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_op = OP_ADD; in_opa = 32'(i); in_opb = 32'd1; in_tag = 4'(8 + i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midrst result queued", 32'(out_valid), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_tag", 32'(out_tag), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst release in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst no stale %0d", i), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    m = model(3'd2, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("model AND sanity", m[31:0], 32'h00F000F0);
    apply_vec(vecs[6], "post-reset AND");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
